// File: rtl/piso_bit_serializer_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
// SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
package serializer_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

`ifdef SERIALIZER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int unsigned frame_len(input int unsigned width);
    return width + (PARITY_EN ? 32'd1 : 32'd0);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_bit_serializer_counter.sv
// Mod-FRAME_LEN bit counter; the terminal flag marks the last bit of a frame.
module ser_bit_counter
  import serializer_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CW        = cnt_width(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_term
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_term ? '0 : r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count == CW'(FRAME_LEN - 1));

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out serializer with valid/ready input and gapless reload.
// Build macro: SERIALIZER_PARITY_EN (adds trailing even-parity bit).
module piso_bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int unsigned FRAME_LEN = frame_len(WIDTH);
  localparam int unsigned CW        = cnt_width(FRAME_LEN);

  state_t                 r_state;
  logic [FRAME_LEN-1:0]   r_shreg;
  logic [FRAME_LEN-1:0]   w_load;
  logic [CW-1:0]          w_count;
  logic                   w_term;
  logic                   w_accept;

  // Parity rides in the shift register just behind the data, so the
  // output tap and zero-fill work unchanged for the extra bit.
`ifdef SERIALIZER_PARITY_EN
  assign w_load = MSB_FIRST ? {din, ^din} : {^din, din};
`else
  assign w_load = din;
`endif

  assign ser_valid = (r_state == S_SHIFT);
  assign ser_last  = ser_valid && w_term;
  assign din_ready = (r_state == S_IDLE) || ser_last;
  assign w_accept  = din_valid && din_ready;
  assign ser_out   = MSB_FIRST ? r_shreg[FRAME_LEN-1] : r_shreg[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
    end else if (w_accept) begin
      r_state <= S_SHIFT;
      r_shreg <= w_load;
    end else if (r_state == S_SHIFT) begin
      r_shreg <= MSB_FIRST ? {r_shreg[FRAME_LEN-2:0], 1'b0}
                           : {1'b0, r_shreg[FRAME_LEN-1:1]};
      if (w_term) begin
        r_state <= S_IDLE;
      end
    end
  end

  ser_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_cnt (
    .clk     (clk),
    .i_rst   (reset),
    .i_clr   (w_accept),
    .i_en    (ser_valid),
    .o_count (w_count),
    .o_term  (w_term)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (w_count <= CW'(FRAME_LEN - 1));
    end
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Scoreboard bench: LSB-first and MSB-first instances share one stimulus stream.
module tb_piso_bit_serializer;

  localparam int unsigned W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         rdy_l, out_l, val_l, last_l;
  logic         rdy_m, out_m, val_m, last_m;

  always #5 clk = ~clk;

  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .ser_out(out_l), .ser_valid(val_l), .ser_last(last_l)
  );

  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .ser_out(out_m), .ser_valid(val_m), .ser_last(last_m)
  );

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [1:0] q_l[$];   // {last, bit}
  logic [1:0] q_m[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference frame: data bits in the chosen order, then optional parity.
  task automatic push_frame(input logic [W-1:0] d, input bit msb);
    logic b;
    logic [1:0] e;
    for (int i = 0; i < int'(FL); i++) begin
      if (i < int'(W)) b = msb ? d[int'(W) - 1 - i] : d[i];
      else             b = ^d;
      e = {(i == int'(FL) - 1), b};
      if (msb) q_m.push_back(e);
      else     q_l.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (mon_en) begin
      chk("lsb_valid", int'(val_l), int'(q_l.size() > 0));
      chk("lsb_ready", int'(rdy_l), int'(q_l.size() <= 1));
      if (q_l.size() > 0) begin
        e = q_l.pop_front();
        chk("lsb_bit",  int'(out_l),  int'(e[0]));
        chk("lsb_last", int'(last_l), int'(e[1]));
      end else begin
        chk("lsb_idle_out",  int'(out_l),  0);
        chk("lsb_idle_last", int'(last_l), 0);
      end
      chk("msb_valid", int'(val_m), int'(q_m.size() > 0));
      chk("msb_ready", int'(rdy_m), int'(q_m.size() <= 1));
      if (q_m.size() > 0) begin
        e = q_m.pop_front();
        chk("msb_bit",  int'(out_m),  int'(e[0]));
        chk("msb_last", int'(last_m), int'(e[1]));
      end else begin
        chk("msb_idle_out",  int'(out_m),  0);
        chk("msb_idle_last", int'(last_m), 0);
      end
    end
  end

  task automatic step(input bit v, input logic [W-1:0] d, input bit r, output bit acc);
    bit a_l, a_m;
    @(negedge clk);
    din_valid = v;
    din       = d;
    reset     = r;
    #1;
    a_l = v && rdy_l;
    a_m = v && rdy_m;
    @(posedge clk);
    acc = a_l && !r;
    if (r) begin
      q_l.delete();
      q_m.delete();
    end else begin
      if (a_l) push_frame(d, 1'b0);
      if (a_m) push_frame(d, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, $urandom(), 1'b0, acc);
  endtask

  task automatic send(input logic [W-1:0] d);
    bit acc;
    step(1'b1, d, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    bit done;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    idle(5);

    send(8'hF0); idle(FL + 2);

    send(8'hA5);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1'b1, 8'h3C, 1'b0, acc);
      done = acc;
    end
    chk("hold_accept", int'(done), 1);
    idle(FL + 2);

    send(8'hFF);
    idle(2);
    step(1'b1, 8'h55, 1'b1, acc);
    idle(1);
    send(8'h00); idle(FL + 2);

    send(8'h80); idle(FL + 2);
    send(8'h07); idle(FL + 2);
    send(8'h03); idle(FL + 2);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 63) == 0, acc);
    end
    idle(2 * FL + 4);

    chk("lsb_drained", q_l.size(), 0);
    chk("msb_drained", q_m.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
